qsort_range_ctrl: RTL and testbench

Upstream sequencer for the Lomuto partition stage. It holds an explicit LIFO of (lo, hi) index ranges and issues one range at a time to the partition stage. It takes back the final pivot index and pushes the resulting non-trivial sub-ranges. It signals sort completion when the LIFO drains.

---
 rtl/qsort_pkg.sv | 32 +++
 rtl/qsort_range_ctrl_if.sv | 21 ++
 rtl/qsort_range_stack.sv | 54 +++++
 rtl/qsort_range_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_qsort_range_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qsort_pkg.sv
// Shared types and constants for the quicksort range sequencer.
// Holds the FSM state enum, the default-width range struct and a clog2 helper.
package qsort_pkg;

  localparam int unsigned DefNElem      = 16;
  localparam int unsigned DefIdxW       = 4;
  localparam int unsigned DefStackDepth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLaunch,
    StWait,
    StPushBig,
    StPushSmall,
    StFinish
  } state_t;

  // Range at the default index width; the controller re-declares it at its own IDX_W.
  typedef struct packed {
    logic [DefIdxW-1:0] lo;
    logic [DefIdxW-1:0] hi;
  } range_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/qsort_range_ctrl_if.sv
// Launch/complete handshake between the range sequencer (master) and the
// Lomuto partition stage (slave).
interface qsort_range_ctrl_if #(
  parameter int unsigned IDX_W = 4
);
  logic             part_start;
  logic [IDX_W-1:0] part_lo;
  logic [IDX_W-1:0] part_hi;
  logic             part_done;
  logic [IDX_W-1:0] part_pivot_idx;

  modport master (
    output part_start, part_lo, part_hi,
    input  part_done, part_pivot_idx
  );

  modport slave (
    input  part_start, part_lo, part_hi,
    output part_done, part_pivot_idx
  );
endinterface

// File: rtl/qsort_range_stack.sv
// Synchronous LIFO of index ranges: one push or pop per cycle, full/empty flags
// and an occupancy count. clr together with push restarts the stack at entry 0.
module qsort_range_stack
  import qsort_pkg::*;
#(
  parameter int unsigned DEPTH  = DefStackDepth,
  parameter type         elem_t = range_t
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  elem_t                        wdata,
  output elem_t                        rdata,
  output logic                         full,
  output logic                         empty,
  output logic [clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned CntW = clog2(DEPTH + 1);
  localparam int unsigned AW   = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  elem_t           mem [DEPTH];
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] base;
  logic [CntW-1:0] top;
  logic            do_push;

  assign base    = clr ? '0 : cnt_q;
  assign top     = cnt_q - CntW'(1);
  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && (clr || !full);
  assign rdata   = empty ? '0 : mem[top[AW-1:0]];

  always_ff @(posedge clock) begin
    if (do_push) mem[base[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (do_push) begin
      cnt_q <= base + CntW'(1);
    end else if (clr) begin
      cnt_q <= '0;
    end else if (pop && !empty) begin
      cnt_q <= top;
    end
  end

endmodule

// File: rtl/qsort_range_ctrl.sv
// Range sequencer for the Lomuto partition stage: LIFO of (lo, hi) ranges, one
// range issued per launch. Optional statistics ports under QSORT_STATS_EN.
module qsort_range_ctrl
  import qsort_pkg::*;
#(
  parameter int unsigned N_ELEM      = DefNElem,
  parameter int unsigned IDX_W       = clog2(N_ELEM),
  parameter int unsigned STACK_DEPTH = DefStackDepth
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [IDX_W:0]                      len,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
`ifdef QSORT_STATS_EN
  output logic [15:0]                         part_count,
  output logic [clog2(STACK_DEPTH+1)-1:0]     max_depth,
`endif
  qsort_range_ctrl_if.master                  part_if
);

  localparam int unsigned SpW = clog2(STACK_DEPTH + 1);

  typedef struct packed {
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
  } idx_range_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] lo_q, lo_d, hi_q, hi_d, piv_q, piv_d;
  logic             err_q, err_d;

  logic             stk_clr, stk_push, stk_pop, stk_full, stk_empty;
  idx_range_t       stk_wdata, stk_rdata;
  logic [SpW-1:0]   sp;

  qsort_range_stack #(
    .DEPTH  (STACK_DEPTH),
    .elem_t (idx_range_t)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .wdata (stk_wdata),
    .rdata (stk_rdata),
    .full  (stk_full),
    .empty (stk_empty),
    .count (sp)
  );

  // Sub-range arithmetic is one bit wider so p-1 / p+1 never wrap.
  logic [IDX_W:0] lo_x, hi_x, piv_x, size_l, size_r;
  logic           l_valid, r_valid, big_l;
  idx_range_t     l_rng, r_rng, big_rng, small_rng;

  assign lo_x      = {1'b0, lo_q};
  assign hi_x      = {1'b0, hi_q};
  assign piv_x     = {1'b0, piv_q};
  assign size_l    = piv_x - lo_x;
  assign size_r    = hi_x - piv_x;
  assign l_valid   = piv_x > (lo_x + (IDX_W+1)'(1));
  assign r_valid   = (piv_x + (IDX_W+1)'(1)) < hi_x;
  assign big_l     = l_valid && (!r_valid || (size_l >= size_r));
  assign l_rng     = '{lo: lo_q, hi: piv_q - IDX_W'(1)};
  assign r_rng     = '{lo: piv_q + IDX_W'(1), hi: hi_q};
  assign big_rng   = big_l ? l_rng : r_rng;
  assign small_rng = big_l ? r_rng : l_rng;

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    piv_d     = piv_q;
    err_d     = err_q;
    stk_clr   = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_wdata = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          err_d = 1'b0;
          if (len >= (IDX_W+1)'(2)) begin
            stk_clr   = 1'b1;
            stk_push  = 1'b1;
            stk_wdata = '{lo: '0, hi: IDX_W'(len - (IDX_W+1)'(1))};
            state_d   = StPop;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StPop: begin
        if (stk_empty) begin
          state_d = StFinish;
        end else begin
          stk_pop = 1'b1;
          lo_d    = stk_rdata.lo;
          hi_d    = stk_rdata.hi;
          state_d = StLaunch;
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (part_if.part_done) begin
          piv_d = part_if.part_pivot_idx;
          if ((part_if.part_pivot_idx < lo_q) || (part_if.part_pivot_idx > hi_q)) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
            state_d = StPushBig;
          end
        end
      end
      StPushBig: begin
        state_d = StPushSmall;
        if (l_valid || r_valid) begin
          if (stk_full) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
            stk_push  = 1'b1;
            stk_wdata = big_rng;
          end
        end
      end
      StPushSmall: begin
        state_d = StPop;
        if (l_valid && r_valid) begin
          if (stk_full) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
            stk_push  = 1'b1;
            stk_wdata = small_rng;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      lo_q    <= '0;
      hi_q    <= '0;
      piv_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      piv_q   <= piv_d;
      err_q   <= err_d;
    end
  end

  assign busy               = (state_q != StIdle) && (state_q != StFinish);
  assign done               = (state_q == StFinish);
  assign err                = err_q;
  assign part_if.part_start = (state_q == StLaunch);
  assign part_if.part_lo    = lo_q;
  assign part_if.part_hi    = hi_q;

`ifdef QSORT_STATS_EN
  logic [15:0]    part_count_q;
  logic [SpW-1:0] max_depth_q;

  always_ff @(posedge clock) begin
    if (reset || (state_q == StIdle && start)) begin
      part_count_q <= '0;
      max_depth_q  <= '0;
    end else begin
      if (state_q == StLaunch && part_count_q != 16'hFFFF) part_count_q <= part_count_q + 16'd1;
      if (sp > max_depth_q) max_depth_q <= sp;
    end
  end

  assign part_count = part_count_q;
  assign max_depth  = max_depth_q;
`endif

  a_sp_bound: assert property (@(posedge clock) disable iff (reset)
    sp <= SpW'(STACK_DEPTH));
  a_len_bound: assert property (@(posedge clock) disable iff (reset)
    (state_q == StIdle && start) |-> (len <= (IDX_W+1)'(N_ELEM)));

endmodule

// File: tb/tb_qsort_range_ctrl.sv
// Directed bench for qsort_range_ctrl with a behavioural Lomuto partition stage
// (3-cycle part_done latency); dut_b uses a one-entry stack to force overflow.
module tb_qsort_range_ctrl;
  import qsort_pkg::*;

  localparam int unsigned IdxW = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start_a = 1'b0, start_b = 1'b0;
  logic [IdxW:0]   len_a = '0, len_b = '0;
  logic            busy_a, done_a, err_a, busy_b, done_b, err_b;
`ifdef QSORT_STATS_EN
  logic [15:0]     pc_a, pc_b;
  logic [3:0]      md_a;
  logic [0:0]      md_b;
`endif

  always #5 clock = ~clock;

  qsort_range_ctrl_if #(.IDX_W(IdxW)) if_a ();
  qsort_range_ctrl_if #(.IDX_W(IdxW)) if_b ();

  qsort_range_ctrl #(.N_ELEM(16), .IDX_W(IdxW), .STACK_DEPTH(8)) dut_a (
    .clock      (clock),
    .reset      (reset),
    .start      (start_a),
    .len        (len_a),
    .busy       (busy_a),
    .done       (done_a),
    .err        (err_a),
`ifdef QSORT_STATS_EN
    .part_count (pc_a),
    .max_depth  (md_a),
`endif
    .part_if    (if_a)
  );

  qsort_range_ctrl #(.N_ELEM(16), .IDX_W(IdxW), .STACK_DEPTH(1)) dut_b (
    .clock      (clock),
    .reset      (reset),
    .start      (start_b),
    .len        (len_b),
    .busy       (busy_b),
    .done       (done_b),
    .err        (err_b),
`ifdef QSORT_STATS_EN
    .part_count (pc_b),
    .max_depth  (md_b),
`endif
    .part_if    (if_b)
  );

  int total = 0;
  int bad   = 0;
  int arr[16];
  int ref_arr[16];
  bit sel = 1'b0;
  bit bad_pivot = 1'b0;
  int ps_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic partition(input int lo, input int hi, output int p);
    int piv, i, t;
    piv = arr[hi];
    i   = lo;
    for (int j = lo; j < hi; j++) begin
      if (arr[j] < piv) begin
        t = arr[i]; arr[i] = arr[j]; arr[j] = t;
        i++;
      end
    end
    t = arr[i]; arr[i] = arr[hi]; arr[hi] = t;
    p = i;
  endtask

  // Partition stage model serving whichever DUT sel points at.
  initial begin
    int mlo, mhi, mp;
    bit msel;
    if_a.part_done = 1'b0; if_a.part_pivot_idx = '0;
    if_b.part_done = 1'b0; if_b.part_pivot_idx = '0;
    forever begin
      @(negedge clock);
      msel = sel;
      if ((msel ? if_b.part_start : if_a.part_start) === 1'b1) begin
        mlo = msel ? int'(if_b.part_lo) : int'(if_a.part_lo);
        mhi = msel ? int'(if_b.part_hi) : int'(if_a.part_hi);
        partition(mlo, mhi, mp);
        if (bad_pivot) mp = mhi + 1;
        ps_cnt++;
        repeat (3) @(posedge clock);
        #1;
        if (msel) begin
          if_b.part_pivot_idx = 4'(mp); if_b.part_done = 1'b1;
        end else begin
          if_a.part_pivot_idx = 4'(mp); if_a.part_done = 1'b1;
        end
        @(posedge clock);
        #1;
        if_a.part_done = 1'b0;
        if_b.part_done = 1'b0;
      end
    end
  end

  task automatic start_sort(input bit s, input int n);
    if (s) begin start_b = 1'b1; len_b = 5'(n); end
    else   begin start_a = 1'b1; len_a = 5'(n); end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Leaves the bench in the FINISH cycle when done is seen.
  task automatic wait_done(input bit s);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ((s ? done_b : done_a) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("done_seen", int'(seen), 1);
  endtask

  task automatic make_ref(input int n);
    int t;
    ref_arr = arr;
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0 && ref_arr[j-1] > ref_arr[j]; j--) begin
        t = ref_arr[j]; ref_arr[j] = ref_arr[j-1]; ref_arr[j-1] = t;
      end
    end
  endtask

  function automatic int mismatches(input int n);
    int m;
    m = 0;
    for (int i = 0; i < n; i++) if (arr[i] != ref_arr[i]) m++;
    return m;
  endfunction

  int ps0;
  int ovf_data[16] = '{8, 3, 12, 1, 15, 0, 7, 2, 9, 14, 4, 11, 6, 13, 5, 10};

  initial begin
    repeat (3) tick();
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_part_start", if_a.part_start, 0);
    check("rst_part_lo", int'(if_a.part_lo), 0);
    check("rst_part_hi", int'(if_a.part_hi), 0);
    check("rst_sp", int'(dut_a.sp), 0);
    reset = 1'b0;
    tick();

    // len 0 and 1: straight to FINISH, no launch
    for (int n = 0; n < 2; n++) begin
      ps0 = ps_cnt;
      start_sort(0, n);
      check("short_done", done_a, 1);
      check("short_busy", busy_a, 0);
      check("short_err", err_a, 0);
      tick();
      check("short_done_drop", done_a, 0);
      check("short_no_launch", ps_cnt - ps0, 0);
    end

    // len 2, {5,3}: launch two cycles after start, single partition
    arr[0] = 5; arr[1] = 3;
    ps0 = ps_cnt;
    start_sort(0, 2);
    check("two_busy", busy_a, 1);
    check("two_no_early_launch", if_a.part_start, 0);
    tick();
    check("two_launch", if_a.part_start, 1);
    check("two_lo", int'(if_a.part_lo), 0);
    check("two_hi", int'(if_a.part_hi), 1);
    tick();
    check("two_launch_pulse", if_a.part_start, 0);
    check("two_hi_stable", int'(if_a.part_hi), 1);
    wait_done(0);
    check("two_busy_fall", busy_a, 0);
    check("two_err", err_a, 0);
    check("two_launches", ps_cnt - ps0, 1);
    check("two_a0", arr[0], 3);
    check("two_a1", arr[1], 5);
    tick();

    // Ascending input, the deepest recursion for last-element pivots
    for (int i = 0; i < 16; i++) arr[i] = i;
    make_ref(16);
    ps0 = ps_cnt;
    start_sort(0, 16);
    wait_done(0);
    check("asc_err", err_a, 0);
    check("asc_sorted", mismatches(16), 0);
    check("asc_launches", ps_cnt - ps0, 15);
`ifdef QSORT_STATS_EN
    check("asc_part_count", int'(pc_a), 15);
    check("asc_max_depth", int'(md_a), 1);
`endif
    tick();

    for (int r = 0; r < 100; r++) begin
      for (int i = 0; i < 16; i++) arr[i] = int'($urandom_range(0, 99));
      make_ref(16);
      start_sort(0, 16);
      wait_done(0);
      check("rand_err", err_a, 0);
      check("rand_sorted", mismatches(16), 0);
      tick();
    end

    // Out-of-range pivot aborts; next start clears err
    for (int i = 0; i < 8; i++) arr[i] = 7 - i;
    bad_pivot = 1'b1;
    ps0 = ps_cnt;
    start_sort(0, 8);
    wait_done(0);
    check("badpiv_err", err_a, 1);
    check("badpiv_launches", ps_cnt - ps0, 1);
    bad_pivot = 1'b0;
    tick();
    check("badpiv_err_sticky", err_a, 1);
    start_sort(0, 1);
    check("badpiv_err_clear", err_a, 0);
    tick();

    // One-entry stack: second push of the first partition overflows
    sel = 1'b1;
    for (int i = 0; i < 16; i++) arr[i] = ovf_data[i];
    ps0 = ps_cnt;
    start_sort(1, 16);
    wait_done(1);
    check("ovf_err", err_b, 1);
    check("ovf_launches", ps_cnt - ps0, 1);
    tick();
    arr[0] = 5; arr[1] = 3;
    start_sort(1, 2);
    check("ovf_err_clear", err_b, 0);
    wait_done(1);
    check("ovf_next_err", err_b, 0);
    check("ovf_next_a0", arr[0], 3);
    check("ovf_next_a1", arr[1], 5);
    tick();
    sel = 1'b0;

    // Reset while WAITing abandons the sort silently
    for (int i = 0; i < 16; i++) arr[i] = 15 - i;
    start_sort(0, 16);
    tick();
    tick();
    check("rstw_in_wait", busy_a, 1);
    reset = 1'b1;
    tick();
    check("rstw_busy", busy_a, 0);
    check("rstw_done", done_a, 0);
    check("rstw_part_start", if_a.part_start, 0);
    check("rstw_sp", int'(dut_a.sp), 0);
    reset = 1'b0;
    repeat (10) begin
      tick();
      check("rstw_idle_done", done_a, 0);
    end
    for (int i = 0; i < 16; i++) arr[i] = (i * 7 + 3) % 16;
    make_ref(16);
    start_sort(0, 16);
    wait_done(0);
    check("rstw_fresh_err", err_a, 0);
    check("rstw_fresh_sorted", mismatches(16), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
